// File: rtl/bs_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bs_arb_pkg
// Description : Shared constants and the round-robin pick function used by
//               the barrel-shift arbiter and its shift core.
//               Contents:
//                 DIR_LEFT / DIR_RIGHT : direction encodings
//                 DW_DEFAULT / SHW     : default data width and shift width
//                 rr_pick()            : one-hot round-robin grant (up to 8)
// Revision    : 1.0 - initial release
// ============================================================================
package bs_arb_pkg;

    localparam logic    DIR_LEFT   = 1'b0;
    localparam logic    DIR_RIGHT  = 1'b1;
    localparam int      DW_DEFAULT = 32;
    localparam int      SHW        = 5;
    localparam int      NREQ_MAX   = 8;

    // Returns a one-hot vector marking the first set bit of valid[nreq-1:0],
    // searching upward from ptr and wrapping at nreq. Bits at or above nreq
    // are never considered, so unused requester slots can never win.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] valid,
        input logic [2:0]          ptr,
        input int                  nreq
    );
        logic [NREQ_MAX-1:0] grant;
        logic                found;
        int                  idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (k < nreq) begin
                // ptr < nreq and k < nreq, so one subtraction wraps correctly
                idx = int'(ptr) + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (!found && valid[idx[2:0]]) begin
                    grant[idx[2:0]] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage : bs_arb_pkg
`default_nettype wire

// File: rtl/barrel_shift_arbiter_core.sv
`default_nettype none
// ============================================================================
// Module      : bs_shifter (+ bs_rot_core when BS_ARB_ROTATE_EN is defined)
// Description : Combinational logarithmic barrel shifter, logical shift with
//               zero fill. i_dir = 1 shifts right, 0 shifts left.
//               Ports (bs_shifter):
//                 i_data  [DW-1:0]  operand
//                 i_dir             direction
//                 i_shift [SHW-1:0] shift amount (modulo DW)
//                 o_data  [DW-1:0]  result
//               Macro BS_ARB_ROTATE_EN additionally builds bs_rot_core, which
//               wraps two shifter instances and adds an i_rot select that
//               turns the operation into a rotate in i_dir.
// Revision    : 1.0 - initial release
// ============================================================================
module bs_shifter
    import bs_arb_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int SHW_P = $clog2(DW)
) (
    input  logic [DW-1:0]    i_data,
    input  logic             i_dir,
    input  logic [SHW_P-1:0] i_shift,
    output logic [DW-1:0]    o_data
);

    logic [DW-1:0] w_stage;

    // One conditional stage per shift-amount bit, stage s moves by 2**s.
    always_comb begin
        w_stage = i_data;
        for (int s = 0; s < SHW_P; s++) begin
            if (i_shift[s]) begin
                if (i_dir == DIR_RIGHT) begin
                    w_stage = w_stage >> (1 << s);
                end else begin
                    w_stage = w_stage << (1 << s);
                end
            end
        end
        o_data = w_stage;
    end

endmodule : bs_shifter

`ifdef BS_ARB_ROTATE_EN
module bs_rot_core
    import bs_arb_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int SHW_P = $clog2(DW)
) (
    input  logic [DW-1:0]    i_data,
    input  logic             i_dir,
    input  logic [SHW_P-1:0] i_shift,
    input  logic             i_rot,
    output logic [DW-1:0]    o_data
);

    logic [DW-1:0]    w_main;
    logic [DW-1:0]    w_wrap;
    logic [SHW_P-1:0] w_comp;

    // The bits pushed out by the main shift re-enter from the opposite side:
    // shift the other way by (DW - n) mod DW. For n = 0 both paths equal
    // i_data, so the OR still passes data through unchanged.
    assign w_comp = ~i_shift + SHW_P'(1);

    bs_shifter #(.DW(DW), .SHW_P(SHW_P)) u_main (
        .i_data  (i_data),
        .i_dir   (i_dir),
        .i_shift (i_shift),
        .o_data  (w_main)
    );

    bs_shifter #(.DW(DW), .SHW_P(SHW_P)) u_wrap (
        .i_data  (i_data),
        .i_dir   (~i_dir),
        .i_shift (w_comp),
        .o_data  (w_wrap)
    );

    assign o_data = i_rot ? (w_main | w_wrap) : w_main;

endmodule : bs_rot_core
`endif
`default_nettype wire

// File: rtl/barrel_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_arbiter
// Description : Round-robin arbiter sharing one barrel shifter among NREQ
//               valid/ready requesters; the winner's result is registered
//               into a single output slot together with its ID.
//               Ports:
//                 clk, rst                 clock, synchronous active-high reset
//                 req_valid/req_ready      per-requester handshake (grant one-hot)
//                 req_dir/req_shift/req_data per-requester operation, packed
//                 resp_valid/resp_ready    result-slot handshake
//                 resp_data/resp_id        result and producing requester
//               Macro BS_ARB_ROTATE_EN adds req_rot (rotate instead of shift)
//               and resp_rot (registered rotate flag).
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_arbiter
    import bs_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEFAULT,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_dir,
    input  logic [NREQ*$clog2(DW)-1:0] req_shift,
    input  logic [NREQ*DW-1:0]     req_data,
`ifdef BS_ARB_ROTATE_EN
    input  logic [NREQ-1:0]        req_rot,
    output logic                   resp_rot,
`endif
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DW-1:0]          resp_data,
    output logic [IDW-1:0]         resp_id
);

    localparam int c_SHW = $clog2(DW);

    logic            r_resp_valid_q, w_resp_valid_d;
    logic [DW-1:0]   r_resp_data_q,  w_resp_data_d;
    logic [IDW-1:0]  r_resp_id_q,    w_resp_id_d;
    logic [IDW-1:0]  r_rr_ptr_q,     w_rr_ptr_d;

    logic            w_slot_free;
    logic [NREQ-1:0] w_grant;
    logic            w_any_grant;
    logic [IDW-1:0]  w_gidx;
    logic [DW-1:0]   w_op_data;
    logic            w_op_dir;
    logic [c_SHW-1:0] w_op_shift;
    logic [DW-1:0]   w_shift_out;

    // ------------------------------------------------------------------
    // Grant: a pure function of req_valid, pointer and slot state. Reset
    // blocks it so nothing is accepted while the slot is being cleared.
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_free = !r_resp_valid_q || resp_ready;
        w_grant     = '0;
        if (!rst && w_slot_free) begin
            w_grant = NREQ'(rr_pick(NREQ_MAX'(req_valid), 3'(r_rr_ptr_q), NREQ));
        end
        w_any_grant = |w_grant;
    end

    assign req_ready = w_grant;

    // One-hot grant to index and operand selection.
    always_comb begin
        w_gidx     = '0;
        w_op_data  = '0;
        w_op_dir   = DIR_LEFT;
        w_op_shift = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx     = IDW'(i);
                w_op_data  = req_data[i*DW +: DW];
                w_op_dir   = req_dir[i];
                w_op_shift = req_shift[i*c_SHW +: c_SHW];
            end
        end
    end

`ifdef BS_ARB_ROTATE_EN
    logic r_resp_rot_q, w_resp_rot_d;
    logic w_op_rot;

    always_comb begin
        w_op_rot = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_op_rot = req_rot[i];
            end
        end
    end

    bs_rot_core #(.DW(DW), .SHW_P(c_SHW)) u_core (
        .i_data  (w_op_data),
        .i_dir   (w_op_dir),
        .i_shift (w_op_shift),
        .i_rot   (w_op_rot),
        .o_data  (w_shift_out)
    );

    always_comb begin
        w_resp_rot_d = r_resp_rot_q;
        if (w_any_grant) begin
            w_resp_rot_d = w_op_rot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_rot_q <= 1'b0;
        end else begin
            r_resp_rot_q <= w_resp_rot_d;
        end
    end

    assign resp_rot = r_resp_rot_q;
`else
    bs_shifter #(.DW(DW), .SHW_P(c_SHW)) u_core (
        .i_data  (w_op_data),
        .i_dir   (w_op_dir),
        .i_shift (w_op_shift),
        .o_data  (w_shift_out)
    );
`endif

    // ------------------------------------------------------------------
    // Slot and pointer next state. A grant always overwrites the slot
    // (covers drain-and-refill in one cycle); a drain without a grant only
    // clears valid so data/id keep their last values.
    // ------------------------------------------------------------------
    always_comb begin
        w_resp_valid_d = r_resp_valid_q;
        w_resp_data_d  = r_resp_data_q;
        w_resp_id_d    = r_resp_id_q;
        w_rr_ptr_d     = r_rr_ptr_q;
        if (w_any_grant) begin
            w_resp_valid_d = 1'b1;
            w_resp_data_d  = w_shift_out;
            w_resp_id_d    = w_gidx;
            w_rr_ptr_d     = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);
        end else if (r_resp_valid_q && resp_ready) begin
            w_resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid_q <= 1'b0;
            r_resp_data_q  <= '0;
            r_resp_id_q    <= '0;
            r_rr_ptr_q     <= '0;
        end else begin
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_data_q  <= w_resp_data_d;
            r_resp_id_q    <= w_resp_id_d;
            r_rr_ptr_q     <= w_rr_ptr_d;
        end
    end

    assign resp_valid = r_resp_valid_q;
    assign resp_data  = r_resp_data_q;
    assign resp_id    = r_resp_id_q;

endmodule : barrel_shift_arbiter
`default_nettype wire

// File: doc/barrel_shift_arbiter.md
Name: barrel_shift_arbiter

Overview:
- Shares one 32-bit barrel shifter datapath between NREQ requesters. Each requester has a valid/ready request channel.
- A round-robin arbiter picks one request per cycle and applies the shift (direction 1 = right, 0 = left; shift amount 0..31). The result is registered into a single output slot with the winner's ID.
- Sits between the shift-using engines and the combinational shifter core. It is the only path through which they reach the shifter.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 32, data width; shift amount width is $clog2(DW)
- IDW, 2, requester ID width, must equal $clog2(NREQ)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_dir  in  NREQ  per-requester direction, 1 = right, 0 = left
- req_shift  in  NREQ*5  packed shift amounts, requester i at [5i+4:5i]
- req_data  in  NREQ*DW  packed operands, requester i at [DW*i+DW-1:DW*i]
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- resp_valid  out  1  result slot holds a valid result
- resp_ready  in  1  consumer accepts the result
- resp_data  out  DW  shifted result
- resp_id  out  IDW  index of the requester that produced resp_data

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: resp_valid=0, resp_data=0, resp_id=0, round-robin pointer rr_ptr=0. req_ready is 0 during reset.
- slot_free = !resp_valid || resp_ready.
- req_ready:
  - Combinational.
  - Zero when !slot_free or when no req_valid bit is set.
  - Otherwise one-hot at the first asserted req_valid index, searching from rr_ptr upward with wrap modulo NREQ.
  - req_ready must never depend on req_ready itself; depends only on req_valid, rr_ptr, resp_valid, resp_ready.
- On a grant to index g at edge T:
  - resp_data <= shift(req_data[g], req_dir[g], req_shift[g]); resp_id <= g; resp_valid <= 1; rr_ptr <= (g+1) mod NREQ.
  - Latency is 1 cycle: the result is visible after edge T.
- Drain:
  - resp_valid && resp_ready with no new grant -> resp_valid <= 0; resp_data and resp_id hold their last values.
  - Drain and grant in the same cycle -> the slot is overwritten with the new result and resp_valid stays 1. Sustained throughput is 1 per cycle.
- Backpressure: resp_valid && !resp_ready -> resp_data, resp_id, resp_valid and rr_ptr all hold; all req_ready are 0.
- Idle: no req_valid -> rr_ptr holds.
- Shift semantics:
  - Logical shift with zero-fill.
  - shift = 0 passes data through unchanged.
  - The shift amount is taken modulo DW (5 bits for DW = 32).
- Requesters must hold req_data, req_dir and req_shift stable while valid and not granted. The arbiter never drops a valid request; worst-case wait is NREQ-1 grants.
- Reset mid-operation: a pending result is discarded (resp_valid=0 on the next cycle) and rr_ptr returns to 0. Requests presented during reset are not granted.
- Out-of-range requester index (NREQ not a power of 2): unused indices are never granted; resp_id is never out of range.

Optional Feature:
- Macro: BS_ARB_ROTATE_EN
- Defined:
  - Adds input port req_rot [NREQ-1:0]. When req_rot[g]=1, the granted operation is a rotate in req_dir[g] instead of a shift.
  - Also adds output resp_rot, 1 bit, registered alongside resp_id; reset value 0.
- Undefined:
  - The ports do not exist and all operations are logical shifts.
  - Timing, arbitration and handshake are identical in both builds.

Decomposition:
- Shared package bs_arb_pkg:
  - constants: DIR_LEFT=1'b0, DIR_RIGHT=1'b1, default DW=32, SHW=5
  - function rr_pick(valid, ptr), returning the one-hot grant vector
- Sub-module:
  - The shift datapath is one instance of the team's existing combinational barrel shifter (direction + 5-bit shift interface).
  - Under BS_ARB_ROTATE_EN it is wrapped in bs_rot_core, which adds the rotate path.
  - The arbiter FSM, pointer and output register stay in barrel_shift_arbiter.

Test Plan:
- Single request: req 0, data=0x8000_0001, dir=1, shift=4, resp_ready=1 -> next cycle resp_valid=1, resp_data=0x0800_0000, resp_id=0. Same request with dir=0 -> resp_data=0x0000_0010. With shift=0 -> resp_data=0x8000_0001.
- Fairness: after reset all 4 requesters valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0,…, one result per cycle, resp_id sequence 0,1,2,3,0.
- Backpressure: result pending, resp_ready=0 for 3 cycles with req 1,2 valid -> all req_ready=0; resp_data/resp_id stable. resp_ready=1 -> req 1 granted that same cycle and the slot is overwritten with no bubble.
- Pointer skip: rr_ptr=2 and only req 0 valid -> grant 0, rr_ptr becomes 1. Then req 0 and 3 valid -> grant 3.
- Reset mid-stream: rst=1 while resp_valid=1 and requests pending -> next cycle resp_valid=0, req_ready=0. After release, all valid -> first grant is 0.
- BS_ARB_ROTATE_EN build: data=0x8000_0001, dir=1, shift=4, req_rot=1 -> resp_data=0x1800_0000, resp_rot=1. dir=0, shift=1 -> resp_data=0x0000_0003.
